// File: rtl/axi_ni_response_depacketizer_ctrl_pkg.sv
// Shared constants for the AXI initiator NI response depacketizer.
// Flit-type encoding, counter/ID widths and AXI response codes, plus small
// flit-type decode helpers used by the sequencing FSM.
package axi_ni_response_depacketizer_ctrl_pkg;

   // Flit type field occupies the low FTYPEWD bits of every flit.
   localparam int FTYPEWD         = 2;
   localparam int COUNTERFLITWD   = 3;
   localparam int PACKETTRANSIDWD = 4;

   localparam logic [FTYPEWD-1:0] FTYPE_BODY     = 2'b00;
   localparam logic [FTYPEWD-1:0] FTYPE_HEAD     = 2'b01;
   localparam logic [FTYPEWD-1:0] FTYPE_TAIL     = 2'b10;
   localparam logic [FTYPEWD-1:0] FTYPE_HEADTAIL = 2'b11;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;

   // Flit opens a packet.
   function automatic logic ftype_is_head(input logic [FTYPEWD-1:0] t);
      return (t == FTYPE_HEAD) || (t == FTYPE_HEADTAIL);
   endfunction

   // Flit closes a packet.
   function automatic logic ftype_is_tail(input logic [FTYPEWD-1:0] t);
      return (t == FTYPE_TAIL) || (t == FTYPE_HEADTAIL);
   endfunction

endpackage

// File: rtl/axi_ni_response_depacketizer_ctrl.sv
// Sequencing FSM for the AXI initiator NI response path.
// Accepts response flits from the NoC ejection port, steers the header flits
// into the external header register (sample_header / flit_count), then emits
// either an AXI R burst (read packets, one beat per payload flit, zero-latency
// pass-through) or a single AXI B beat (write packets).
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   flit, flit_valid, flit_ready    NoC ejection handshake
//   sample_header, flit_count       capture strobe/index to header register
//   packet_type_is_read,
//   message_is_locked, received_id  decoded header fields
//   rvalid/rready/rdata/rid/rresp/rlast  AXI R channel
//   bvalid/bready/bid/bresp         AXI B channel
//   protocol_error                  one-cycle pulse on malformed packet
module axi_ni_response_depacketizer_ctrl
   import axi_ni_response_depacketizer_ctrl_pkg::*;
#(
   parameter int FLIT_WIDTH       = 32,
   parameter int RESP_HEADERFLITS = 2,
   parameter int DATA_WIDTH       = FLIT_WIDTH - FTYPEWD
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [FLIT_WIDTH-1:0]      flit,
   input  logic                       flit_valid,
   output logic                       flit_ready,
   output logic                       sample_header,
   output logic [COUNTERFLITWD-1:0]   flit_count,
   input  logic                       packet_type_is_read,
   input  logic                       message_is_locked,
   input  logic [PACKETTRANSIDWD-1:0] received_id,
   output logic                       rvalid,
   input  logic                       rready,
   output logic [DATA_WIDTH-1:0]      rdata,
   output logic [PACKETTRANSIDWD-1:0] rid,
   output logic [1:0]                 rresp,
   output logic                       rlast,
   output logic                       bvalid,
   input  logic                       bready,
   output logic [PACKETTRANSIDWD-1:0] bid,
   output logic [1:0]                 bresp,
   output logic                       protocol_error
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] HEADER = 3'd1;
   localparam logic [2:0] DECODE = 3'd2;
   localparam logic [2:0] RDATA  = 3'd3;
   localparam logic [2:0] BRESP  = 3'd4;

   localparam logic [COUNTERFLITWD-1:0] LAST_IDX = COUNTERFLITWD'(RESP_HEADERFLITS - 1);

   logic [2:0]         state;
   logic [FTYPEWD-1:0] ftype;
   logic               acc;
   logic               f_head;
   logic               f_tail;
   // Whether the last header flit also closed the packet; decides read/write legality in DECODE.
   logic               last_hdr_tail;

   assign ftype  = flit[FTYPEWD-1:0];
   assign f_head = ftype_is_head(ftype);
   assign f_tail = ftype_is_tail(ftype);
   assign acc    = flit_valid & flit_ready;

   assign rdata = flit[FLIT_WIDTH-1:FTYPEWD];
   assign rid   = received_id;
   assign bid   = received_id;
   assign rresp = message_is_locked ? AXI_RESP_EXOKAY : AXI_RESP_OKAY;
   assign bresp = message_is_locked ? AXI_RESP_EXOKAY : AXI_RESP_OKAY;
   assign rlast = (ftype == FTYPE_TAIL);

   always_comb begin
      flit_ready    = 1'b0;
      sample_header = 1'b0;
      rvalid        = 1'b0;
      case (state)
         IDLE: begin
            flit_ready    = 1'b1;
            sample_header = flit_valid & f_head;
         end
         HEADER: begin
            flit_ready    = 1'b1;
            sample_header = flit_valid;
         end
         RDATA: begin
            // A stray head flit is never shown on R; it is swallowed immediately as an error.
            rvalid     = flit_valid & ~f_head;
            flit_ready = f_head ? 1'b1 : rready;
         end
         default: begin
            flit_ready    = 1'b0;
            sample_header = 1'b0;
            rvalid        = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         flit_count     <= '0;
         bvalid         <= 1'b0;
         protocol_error <= 1'b0;
         last_hdr_tail  <= 1'b0;
      end else begin
         protocol_error <= 1'b0;
         case (state)
            IDLE: begin
               if (acc) begin
                  if (f_head) begin
                     if (RESP_HEADERFLITS == 1) begin
                        last_hdr_tail <= f_tail;
                        state         <= DECODE;
                     end else if (f_tail) begin
                        // HEADTAIL cannot carry a multi-flit header.
                        protocol_error <= 1'b1;
                     end else begin
                        flit_count <= 1;
                        state      <= HEADER;
                     end
                  end else begin
                     protocol_error <= 1'b1;
                  end
               end
            end
            HEADER: begin
               if (acc) begin
                  if (flit_count == LAST_IDX) begin
                     flit_count    <= '0;
                     last_hdr_tail <= f_tail;
                     state         <= DECODE;
                  end else if (f_tail) begin
                     flit_count     <= '0;
                     protocol_error <= 1'b1;
                     state          <= IDLE;
                  end else begin
                     flit_count <= flit_count + 1'b1;
                  end
               end
            end
            DECODE: begin
               // Header register outputs are stable here.
               if (packet_type_is_read) begin
                  if (last_hdr_tail) begin
                     protocol_error <= 1'b1;
                     state          <= IDLE;
                  end else begin
                     state <= RDATA;
                  end
               end else if (last_hdr_tail) begin
                  bvalid <= 1'b1;
                  state  <= BRESP;
               end else begin
                  // Write packet still open after its header: remaining flits surface as errors in IDLE.
                  protocol_error <= 1'b1;
                  state          <= IDLE;
               end
            end
            RDATA: begin
               if (acc) begin
                  if (f_head) begin
                     protocol_error <= 1'b1;
                     state          <= IDLE;
                  end else if (ftype == FTYPE_TAIL) begin
                     state <= IDLE;
                  end
               end
            end
            BRESP: begin
               if (bready) begin
                  bvalid <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_ni_response_depacketizer_ctrl.sv
module tb_axi_ni_response_depacketizer_ctrl;
   import axi_ni_response_depacketizer_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] flit;
   logic        flit_valid;
   logic        flit_ready;
   logic        sample_header;
   logic [2:0]  flit_count;
   logic        packet_type_is_read;
   logic        message_is_locked;
   logic [3:0]  received_id;
   logic        rvalid;
   logic        rready;
   logic [29:0] rdata;
   logic [3:0]  rid;
   logic [1:0]  rresp;
   logic        rlast;
   logic        bvalid;
   logic        bready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        protocol_error;

   axi_ni_response_depacketizer_ctrl #(.FLIT_WIDTH(32), .RESP_HEADERFLITS(2)) dut (
      .clk(clk), .rst(rst), .flit(flit), .flit_valid(flit_valid), .flit_ready(flit_ready),
      .sample_header(sample_header), .flit_count(flit_count),
      .packet_type_is_read(packet_type_is_read), .message_is_locked(message_is_locked),
      .received_id(received_id), .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid),
      .rresp(rresp), .rlast(rlast), .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
      .protocol_error(protocol_error)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [29:0] p, input logic [1:0] t);
      return {p, t};
   endfunction

   // Monitor: everything sampled on the falling edge.
   int          cyc = 0;
   int          beat_data[$];
   int          beat_last[$];
   int          beat_id[$];
   int          beat_resp[$];
   int          beat_cyc[$];
   int          sh_cnt[$];
   int          head_cyc = 0;
   int          err_cnt = 0;
   int          stall_cnt = 0;
   int          b_cycles = 0;
   int          fr_viol = 0;
   int          last_bid = 0;
   int          last_bresp = 0;
   logic        hold_en = 1'b0;
   int          hold_seen = 0;
   int          hold_bad = 0;
   logic        prev_stall = 1'b0;
   logic [29:0] prev_data = '0;
   logic        toggle = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rvalid && rready) begin
         beat_data.push_back(int'(rdata));
         beat_last.push_back(int'(rlast));
         beat_id.push_back(int'(rid));
         beat_resp.push_back(int'(rresp));
         beat_cyc.push_back(cyc);
      end
      if (sample_header && flit_valid && flit_ready) begin
         sh_cnt.push_back(int'(flit_count));
         if (flit_count == 3'd0) head_cyc = cyc;
      end
      if (protocol_error) err_cnt++;
      if (flit_valid && !flit_ready) stall_cnt++;
      if (bvalid) begin
         b_cycles++;
         last_bid   = int'(bid);
         last_bresp = int'(bresp);
         if (flit_ready) fr_viol++;
      end
      if (hold_en && prev_stall) begin
         hold_seen++;
         if (!rvalid || rdata != prev_data) hold_bad++;
      end
      prev_stall = rvalid && !rready;
      prev_data  = rdata;
   end

   // Presents one flit and holds it until consumed (bounded).
   task automatic send(input logic [31:0] f);
      int  n;
      logic took;
      flit       = f;
      flit_valid = 1'b1;
      n          = 0;
      took       = 1'b0;
      while (!took) begin
         @(negedge clk);
         took = flit_ready;
         @(posedge clk);
         #1;
         if (toggle) rready = ~rready;
         n++;
         if (!took && n > 50) begin
            chk("send_timeout", 64'd0, 64'd1);
            took = 1'b1;
         end
      end
   endtask

   task automatic idle(input int n);
      flit_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   int base;
   int sh_base;
   int e0;
   int s0;
   int b0;
   int v0;
   int n;

   initial begin
      rst = 1'b1; flit = '0; flit_valid = 1'b0; rready = 1'b1; bready = 1'b0;
      packet_type_is_read = 1'b1; message_is_locked = 1'b0; received_id = 4'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rst_flit_ready", 64'(flit_ready), 64'd1);
      chk("rst_sample_header", 64'(sample_header), 64'd0);
      chk("rst_rvalid", 64'(rvalid), 64'd0);
      chk("rst_bvalid", 64'(bvalid), 64'd0);
      chk("rst_protocol_error", 64'(protocol_error), 64'd0);
      chk("rst_flit_count", 64'(flit_count), 64'd0);

      // 1: read, two header flits, four payload beats
      packet_type_is_read = 1'b1; message_is_locked = 1'b0; received_id = 4'd5;
      base = beat_data.size(); sh_base = sh_cnt.size(); e0 = err_cnt;
      send(mk(30'h100, FTYPE_HEAD));
      send(mk(30'h5, FTYPE_BODY));
      send(mk(30'h11, FTYPE_BODY));
      send(mk(30'h22, FTYPE_BODY));
      send(mk(30'h33, FTYPE_BODY));
      send(mk(30'h44, FTYPE_TAIL));
      idle(3);
      chk("t1_sh_num", 64'(sh_cnt.size() - sh_base), 64'd2);
      if (sh_cnt.size() - sh_base == 2) begin
         chk("t1_sh_cnt0", 64'(sh_cnt[sh_base]), 64'd0);
         chk("t1_sh_cnt1", 64'(sh_cnt[sh_base+1]), 64'd1);
      end
      chk("t1_beats", 64'(beat_data.size() - base), 64'd4);
      if (beat_data.size() - base == 4) begin
         chk("t1_lat", 64'(beat_cyc[base] - head_cyc), 64'd3);
         chk("t1_d0", 64'(beat_data[base]), 64'h11);
         chk("t1_d1", 64'(beat_data[base+1]), 64'h22);
         chk("t1_d2", 64'(beat_data[base+2]), 64'h33);
         chk("t1_d3", 64'(beat_data[base+3]), 64'h44);
         chk("t1_last", 64'({beat_last[base][0], beat_last[base+1][0], beat_last[base+2][0], beat_last[base+3][0]}), 64'b0001);
         chk("t1_rid", 64'(beat_id[base+3]), 64'd5);
         chk("t1_rresp", 64'(beat_resp[base]), 64'd0);
      end
      chk("t1_no_err", 64'(err_cnt - e0), 64'd0);

      // 2: exclusive write, bready held low 4 cycles
      packet_type_is_read = 1'b0; message_is_locked = 1'b1; received_id = 4'd3;
      b0 = b_cycles; v0 = fr_viol;
      send(mk(30'h0, FTYPE_HEAD));
      send(mk(30'h3, FTYPE_TAIL));
      flit_valid = 1'b0;
      n = 0;
      while (!bvalid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("t2_bvalid_seen", 64'(bvalid), 64'd1);
      repeat (4) @(posedge clk);
      #1 bready = 1'b1;
      @(posedge clk);
      #1 bready = 1'b0;
      #1;
      chk("t2_bvalid_drop", 64'(bvalid), 64'd0);
      chk("t2_b_cycles", 64'(b_cycles - b0), 64'd5);
      chk("t2_bid", 64'(last_bid), 64'd3);
      chk("t2_bresp", 64'(last_bresp), 64'd1);
      chk("t2_fr_low", 64'(fr_viol - v0), 64'd0);
      chk("t2_idle_ready", 64'(flit_ready), 64'd1);

      // 3: read with rready toggling
      packet_type_is_read = 1'b1; message_is_locked = 1'b1; received_id = 4'd7;
      base = beat_data.size();
      send(mk(30'h200, FTYPE_HEAD));
      send(mk(30'h7, FTYPE_BODY));
      hold_en = 1'b1; toggle = 1'b1;
      send(mk(30'hA1, FTYPE_BODY));
      send(mk(30'hA2, FTYPE_BODY));
      send(mk(30'hA3, FTYPE_TAIL));
      toggle = 1'b0; rready = 1'b1;
      idle(2);
      hold_en = 1'b0;
      chk("t3_beats", 64'(beat_data.size() - base), 64'd3);
      if (beat_data.size() - base == 3) begin
         chk("t3_d0", 64'(beat_data[base]), 64'hA1);
         chk("t3_d1", 64'(beat_data[base+1]), 64'hA2);
         chk("t3_d2", 64'(beat_data[base+2]), 64'hA3);
         chk("t3_last", 64'({beat_last[base][0], beat_last[base+1][0], beat_last[base+2][0]}), 64'b001);
         chk("t3_rresp", 64'(beat_resp[base+1]), 64'd1);
      end
      chk("t3_hold_seen", 64'(hold_seen > 0), 64'd1);
      chk("t3_hold_ok", 64'(hold_bad), 64'd0);

      // 4: stray BODY in IDLE, then a good packet
      e0 = err_cnt;
      send(mk(30'h3C, FTYPE_BODY));
      flit_valid = 1'b0;
      chk("t4_err_pulse", 64'(protocol_error), 64'd1);
      @(posedge clk); #1;
      chk("t4_err_clear", 64'(protocol_error), 64'd0);
      chk("t4_err_once", 64'(err_cnt - e0), 64'd1);
      received_id = 4'd2; message_is_locked = 1'b0;
      base = beat_data.size();
      send(mk(30'h300, FTYPE_HEAD));
      send(mk(30'h2, FTYPE_BODY));
      send(mk(30'h55, FTYPE_TAIL));
      idle(2);
      chk("t4_beats", 64'(beat_data.size() - base), 64'd1);
      if (beat_data.size() - base == 1) begin
         chk("t4_d0", 64'(beat_data[base]), 64'h55);
         chk("t4_rid", 64'(beat_id[base]), 64'd2);
         chk("t4_rlast", 64'(beat_last[base]), 64'd1);
      end

      // 5: reset mid-burst
      received_id = 4'd4;
      send(mk(30'h400, FTYPE_HEAD));
      send(mk(30'h4, FTYPE_BODY));
      send(mk(30'h61, FTYPE_BODY));
      rready = 1'b0;
      flit = mk(30'h62, FTYPE_BODY);
      flit_valid = 1'b1;
      #1;
      chk("t5_rvalid_before", 64'(rvalid), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0; flit_valid = 1'b0;
      #1;
      chk("t5_rvalid", 64'(rvalid), 64'd0);
      chk("t5_flit_count", 64'(flit_count), 64'd0);
      chk("t5_idle_ready", 64'(flit_ready), 64'd1);
      rready = 1'b1; received_id = 4'd9;
      base = beat_data.size();
      send(mk(30'h500, FTYPE_HEAD));
      send(mk(30'h9, FTYPE_BODY));
      send(mk(30'h77, FTYPE_TAIL));
      idle(2);
      chk("t5_beats", 64'(beat_data.size() - base), 64'd1);
      if (beat_data.size() - base == 1) begin
         chk("t5_d0", 64'(beat_data[base]), 64'h77);
         chk("t5_rid", 64'(beat_id[base]), 64'd9);
      end

      // 6: back-to-back reads, flit_valid never drops
      received_id = 4'd1;
      base = beat_data.size(); s0 = stall_cnt;
      send(mk(30'h600, FTYPE_HEAD));
      send(mk(30'h1, FTYPE_BODY));
      send(mk(30'h01, FTYPE_BODY));
      send(mk(30'h02, FTYPE_TAIL));
      send(mk(30'h700, FTYPE_HEAD));
      send(mk(30'h1, FTYPE_BODY));
      send(mk(30'h03, FTYPE_TAIL));
      idle(2);
      chk("t6_stalls", 64'(stall_cnt - s0), 64'd2);
      chk("t6_beats", 64'(beat_data.size() - base), 64'd3);
      if (beat_data.size() - base == 3) begin
         chk("t6_data", 64'({beat_data[base][7:0], beat_data[base+1][7:0], beat_data[base+2][7:0]}), 64'h010203);
         chk("t6_last", 64'({beat_last[base][0], beat_last[base+1][0], beat_last[base+2][0]}), 64'b011);
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
